// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin front end for a single-port data RAM.
// Serialises one access per IDLE/ACCESS pair, returns read data with a
// one-cycle valid pulse, and can zero the whole array by walking every address.
module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_write,
    output logic              ram_read,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    // cnt is one bit wider than the address so the final-address test is unambiguous
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              last_reg, last_next;
    logic              clear_pend_reg, clear_pend_next;
    logic [ADDR_W:0]   cnt_reg, cnt_next;
    logic              sel_port_reg, sel_port_next;
    logic              sel_we_reg, sel_we_next;
    logic [ADDR_W-1:0] sel_addr_reg, sel_addr_next;
    logic [DATA_W-1:0] sel_wdata_reg, sel_wdata_next;
    logic              clear_done_reg, clear_done_next;
    logic              rvalid0_reg, rvalid0_next;
    logic              rvalid1_reg, rvalid1_next;
    logic [DATA_W-1:0] rdata0_reg, rdata1_reg;
    logic              pick;

    // Round-robin choice: on a tie the port that was not granted last wins;
    // otherwise the lone requester (port 1 if req1, else port 0).
    assign pick = (req0 && req1) ? ~last_reg : req1;

    assign clear_done = clear_done_reg;
    assign rvalid0    = rvalid0_reg;
    assign rvalid1    = rvalid1_reg;
    assign rdata0     = rdata0_reg;
    assign rdata1     = rdata1_reg;

    // Next-state, request selection and RAM-side outputs
    always_comb begin
        state_next      = state_reg;
        last_next       = last_reg;
        clear_pend_next = clear_pend_reg;
        cnt_next        = cnt_reg;
        sel_port_next   = sel_port_reg;
        sel_we_next     = sel_we_reg;
        sel_addr_next   = sel_addr_reg;
        sel_wdata_next  = sel_wdata_reg;
        clear_done_next = 1'b0;
        rvalid0_next    = 1'b0;
        rvalid1_next    = 1'b0;
        gnt0            = 1'b0;
        gnt1            = 1'b0;
        busy            = 1'b0;
        ram_addr        = '0;
        ram_write       = 1'b0;
        ram_read        = 1'b0;
        ram_wdata       = '0;

        case (state_reg)
            IDLE: begin
                if (clear_req || clear_pend_reg) begin
                    state_next      = CLEAR;
                    cnt_next        = '0;
                    clear_pend_next = 1'b0;
                end else if (req0 || req1) begin
                    state_next     = ACCESS;
                    last_next      = pick;
                    sel_port_next  = pick;
                    sel_we_next    = pick ? we1 : we0;
                    sel_addr_next  = pick ? addr1 : addr0;
                    sel_wdata_next = pick ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                busy         = 1'b1;
                ram_addr     = sel_addr_reg;
                ram_write    = sel_we_reg;
                ram_read     = ~sel_we_reg;
                ram_wdata    = sel_we_reg ? sel_wdata_reg : '0;
                gnt0         = ~sel_port_reg;
                gnt1         = sel_port_reg;
                rvalid0_next = ~sel_we_reg & ~sel_port_reg;
                rvalid1_next = ~sel_we_reg & sel_port_reg;
                if (clear_req) begin
                    clear_pend_next = 1'b1;
                end
                state_next = IDLE;
            end
            CLEAR: begin
                busy      = 1'b1;
                ram_write = 1'b1;
                ram_addr  = cnt_reg[ADDR_W-1:0];
                cnt_next  = cnt_reg + (ADDR_W + 1)'(1);
                if (clear_req) begin
                    clear_pend_next = 1'b1;
                end
                if (cnt_reg == LAST_CNT) begin
                    state_next      = IDLE;
                    clear_done_next = 1'b1;
                    // a clear request landing on the final cycle is kept for later
                    clear_pend_next = clear_req;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, selection registers and registered read-return / done pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_reg       <= 1'b1;
            clear_pend_reg <= 1'b0;
            cnt_reg        <= '0;
            sel_port_reg   <= 1'b0;
            sel_we_reg     <= 1'b0;
            sel_addr_reg   <= '0;
            sel_wdata_reg  <= '0;
            clear_done_reg <= 1'b0;
            rvalid0_reg    <= 1'b0;
            rvalid1_reg    <= 1'b0;
            rdata0_reg     <= '0;
            rdata1_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            last_reg       <= last_next;
            clear_pend_reg <= clear_pend_next;
            cnt_reg        <= cnt_next;
            sel_port_reg   <= sel_port_next;
            sel_we_reg     <= sel_we_next;
            sel_addr_reg   <= sel_addr_next;
            sel_wdata_reg  <= sel_wdata_next;
            clear_done_reg <= clear_done_next;
            rvalid0_reg    <= rvalid0_next;
            rvalid1_reg    <= rvalid1_next;
            if (rvalid0_next) begin
                rdata0_reg <= ram_rdata;
            end
            if (rvalid1_next) begin
                rdata1_reg <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural 32x32 RAM
// (combinational read, write on the rising edge) attached to the ram_* pins.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        clear_req = 1'b0;
    logic        busy, clear_done;
    logic [4:0]  ram_addr;
    logic        ram_write, ram_read;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [32];

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_read(ram_read),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    // RAM model
    always @(posedge clock) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access on a single port; returns read data and the number
    // of cycles from request to grant.
    task automatic access(input bit p, input logic we, input logic [4:0] a,
                          input logic [31:0] d, output logic [31:0] q, output int lat);
        @(negedge clock);
        if (!p) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else    begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!(p ? gnt1 : gnt0) && lat < 200);
        check("gnt_timeout", 32'(lat < 200), 32'd1);
        check("gnt_other", 32'(p ? gnt0 : gnt1), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clock);
        check("rvalid", 32'(p ? rvalid1 : rvalid0), 32'(!we));
        q = p ? rdata1 : rdata0;
        $display("access port=%0d we=%0d addr=%0d wdata=%h rdata=%h lat=%0d", p, we, a, d, q, lat);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic fill();
        logic [31:0] q;
        int lat;
        for (int i = 0; i < 32; i++) access(1'b0, 1'b1, 5'(i), 32'(i + 1), q, lat);
    endtask

    initial begin
        logic [31:0] q;
        int lat;
        int ord [4];
        int gc [4];
        int n, other, busy_cnt, done_cnt, done_cyc, gnt_cyc;
        logic [31:0] latest;

        // ---- reset state ----
        repeat (3) @(negedge clock);
        check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        check("rst_busy_done", 32'({busy, clear_done}), 32'd0);
        check("rst_ram_ctl", 32'({ram_write, ram_read, ram_addr}), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        reset = 1'b0;

        // ---- port 0 write then read ----
        access(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, q, lat);
        check("wr_lat", 32'(lat), 32'd1);
        access(1'b0, 1'b0, 5'd5, 32'h0, q, lat);
        check("rd_lat", 32'(lat), 32'd1);
        check("rd_data0", q, 32'hDEADBEEF);
        check("rdata1_idle", rdata1, 32'd0);

        // ---- both ports continuously: order 0,1,0,1 ----
        do_reset();
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd1; wdata0 = 32'hA0000000;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd1;
        latest = 32'h0;
        n = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge clock);
            check("both_gnt", 32'(gnt0 & gnt1), 32'd0);
            check("both_rvalid", 32'(rvalid0 & rvalid1), 32'd0);
            if (rvalid1) begin
                check("rr_rdata1", rdata1, latest);
                $display("rr read port=1 data=%h", rdata1);
            end
            if (gnt0 || gnt1) begin
                ord[n] = gnt1 ? 1 : 0;
                gc[n] = c;
                n++;
                $display("rr grant port=%0d cycle=%0d", gnt1 ? 1 : 0, c);
                if (gnt0) begin
                    latest = wdata0;
                    wdata0 = wdata0 + 32'd1;
                end
                if (n == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        check("rr_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) check("rr_order", 32'(ord[i]), 32'(i % 2));
        for (int i = 1; i < 4; i++) check("rr_gap", 32'(gc[i] - gc[i-1]), 32'd2);
        @(negedge clock);
        check("rr_last_rvalid", 32'(rvalid1), 32'd1);
        check("rr_last_rdata", rdata1, latest);

        // ---- port 1 alone: four writes to addr 31 ----
        @(negedge clock);
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'd31; wdata1 = 32'h12345678;
        n = 0;
        other = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge clock);
            if (gnt0) other++;
            if (gnt1) begin
                gc[n] = c;
                n++;
                $display("p1 write grant cycle=%0d", c);
                if (n == 4) req1 = 1'b0;
            end
        end
        check("p1_count", 32'(n), 32'd4);
        check("p1_no_gnt0", 32'(other), 32'd0);
        for (int i = 1; i < 4; i++) check("p1_gap", 32'(gc[i] - gc[i-1]), 32'd2);
        access(1'b1, 1'b0, 5'd31, 32'h0, q, lat);
        check("p1_readback", q, 32'h12345678);

        // ---- fill then full clear ----
        fill();
        @(negedge clock);
        clear_req = 1'b1;
        busy_cnt = 0; done_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            clear_req = 1'b0;
            if (busy) begin
                check("clr_addr", 32'(ram_addr), 32'(c - 1));
                busy_cnt++;
            end
            if (clear_done) begin
                done_cnt++;
                done_cyc = c;
                check("clr_busy_at_done", 32'(busy), 32'd0);
            end
        end
        $display("clear busy_cycles=%0d done_pulses=%0d done_cycle=%0d", busy_cnt, done_cnt, done_cyc);
        check("clr_busy_cnt", 32'(busy_cnt), 32'd32);
        check("clr_done_cnt", 32'(done_cnt), 32'd1);
        check("clr_done_cyc", 32'(done_cyc), 32'd33);
        for (int i = 0; i < 32; i++) begin
            access(1'b1, 1'b0, 5'(i), 32'h0, q, lat);
            check("clr_read", q, 32'd0);
        end

        // ---- clear and req0 together: clear first ----
        access(1'b0, 1'b1, 5'd3, 32'h55AA55AA, q, lat);
        access(1'b0, 1'b0, 5'd3, 32'h0, q, lat);
        check("pre_clr_rdata0", q, 32'h55AA55AA);
        @(negedge clock);
        clear_req = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
        done_cyc = 0; gnt_cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            clear_req = 1'b0;
            if (clear_done) done_cyc = c;
            if (gnt0) begin
                gnt_cyc = c;
                req0 = 1'b0;
            end
            if (rvalid0) check("cr_rdata0", rdata0, 32'd0);
        end
        $display("clear+req done_cycle=%0d gnt0_cycle=%0d", done_cyc, gnt_cyc);
        check("cr_done_cyc", 32'(done_cyc), 32'd33);
        check("cr_gnt_cyc", 32'(gnt_cyc), 32'd34);
        check("cr_rdata0_final", rdata0, 32'd0);

        // ---- reset in the middle of a clear ----
        fill();
        @(negedge clock);
        clear_req = 1'b1;
        n = 0;
        for (int c = 1; c <= 60 && n == 0; c++) begin
            @(negedge clock);
            clear_req = 1'b0;
            if (busy && ram_addr == 5'd9) begin
                reset = 1'b1;
                n = 1;
            end
        end
        check("mr_reached", 32'(n), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_ram_write", 32'(ram_write), 32'd0);
        check("mr_done", 32'(clear_done), 32'd0);
        check("mr_rdata0", rdata0, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (clear_done || busy) done_cnt++;
        end
        check("mr_no_done", 32'(done_cnt), 32'd0);
        for (int i = 0; i < 32; i++) begin
            access(1'b1, 1'b0, 5'(i), 32'h0, q, lat);
            check("mr_read", q, (i < 10) ? 32'd0 : 32'(i + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and clear sequencer for the 32 x 32-bit single-port data RAM. It sits between two requesters (port 0: CPU load/store unit, port 1: debug/loader port) and the RAM's addr/write/read/input_data/output_data pins. It serialises their accesses one at a time, returns read data with a valid pulse, and can zero the whole array on command by walking all 32 addresses.

## Interface
Parameters:
- ADDR_W, 5: RAM address width; depth = 2**ADDR_W = 32 words.
- DATA_W, 32: word width.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- req0 / req1  in  1  access request, held until the matching gnt pulse.
- we0 / we1  in  1  1 = write, 0 = read; sampled with req.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  one-cycle pulse: the request has been consumed.
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata is valid (reads only).
- rdata0 / rdata1  out  DATA_W  read data, held until the port's next read completes.
- clear_req  in  1  pulse: zero the entire RAM.
- busy  out  1  high in ACCESS and CLEAR.
- clear_done  out  1  one-cycle pulse after the last clear write.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_write  out  1  to RAM write.
- ram_read  out  1  to RAM read.
- ram_wdata  out  DATA_W  to RAM input_data.
- ram_rdata  in  DATA_W  from RAM output_data (combinational read).

## Operation
- States: IDLE, ACCESS, CLEAR.
- IDLE: all ram_* outputs are 0.
- In IDLE, the choice at each rising edge is made in this order:
  - clear_req (or a latched clear_pend) -> CLEAR, cnt = 0.
  - Else, if any req is high: pick a port and latch its we/addr/wdata into sel regs -> ACCESS.
  - Else stay in IDLE.
- Round-robin: pointer `last` holds the last granted port.
  - If both ports request, the port != last wins.
  - A single requester always wins.
  - `last` updates on each grant.
- clear_req arriving in ACCESS or CLEAR sets clear_pend, which is serviced at the next IDLE decision.
- ACCESS (exactly 1 cycle):
  - ram_addr = sel_addr.
  - Write: ram_write = 1, ram_wdata = sel_wdata.
  - Read: ram_read = 1; rdata_k <= ram_rdata at the end of the cycle.
  - gnt_k = 1.
  - Next state is IDLE.
- Requester rule: after seeing gnt, it drops req or presents a new request on the next cycle. The arbiter never samples req during ACCESS.
- CLEAR:
  - Each cycle: ram_write = 1, ram_addr = cnt, ram_wdata = 0; cnt increments.
  - After the cnt = 31 cycle: clear_done pulses for 1 cycle (registered), clear_pend is cleared, state -> IDLE.
  - Requests stay pending and are not granted during CLEAR.
- cnt is ADDR_W+1 bits, so the end test has no wrap-around ambiguity.

## Timing
- Reset values: state = IDLE, last = 1 (port 0 wins the first tie), clear_pend = 0, cnt = 0; all gnt/rvalid/clear_done/busy/ram_* = 0; rdata0 = rdata1 = 0.
- Reset mid-ACCESS or mid-CLEAR aborts at the next edge: no gnt, rvalid or clear_done is produced, and partially cleared contents remain.
- Read latency: req high at edge E -> ACCESS in cycle E..E+1 with gnt -> rvalid and rdata valid in cycle E+1..E+2. The request-to-data latency is 2 cycles.
- Write: the RAM updates at the rising edge ending the ACCESS cycle; gnt is high during that cycle.
- Throughput: one access per 2 cycles (IDLE, ACCESS alternate). Back-to-back requests from both ports alternate 0, 1, 0, 1.
- Clear: 32 write cycles. clear_done is high in the cycle after the addr-31 write. busy is high for all 32 cycles and low with clear_done.
- Simultaneous clear_req and req in IDLE: clear wins, and the request is served right after clear_done.
- gnt and rvalid are never high for both ports in the same cycle.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> gnt0 each time; rvalid0 2 cycles after the read req with rdata0 = 0xDEADBEEF; rdata1 remains 0.
- Both ports hold req continuously: port 0 writes addr 1, port 1 reads addr 1 -> grants in order 0, 1, 0, 1; port 1 reads back port 0's latest data.
- Port 1 alone writes addr 31 = 0x12345678 four times -> four gnt1 pulses, 2 cycles apart; no gnt0.
- Fill addrs 0..31 with index+1, then pulse clear_req -> busy for 32 cycles, clear_done once; every subsequent read returns 0.
- clear_req together with req0 (read addr 3) in IDLE -> clear runs first; gnt0 after clear_done; rdata0 = 0.
- Assert reset at clear cycle 10 -> outputs go to reset values next edge; no clear_done; addrs 10..31 keep their old contents; addrs 0..9 read 0.
